// File: rtl/alu_mc_if.sv
// alu_mc_if: request/result handshake bundle between an ALU client and alu_mc.
interface alu_mc_if #(parameter int DATA_W = 32);
    logic              in_valid, in_ready, pc_en, imm_en;
    logic              out_valid, out_ready, zero;
    logic [DATA_W-1:0] pc, reg_1, reg_2, imm, alu_result;
    logic [3:0]        aluop;
    modport master(output in_valid, pc_en, imm_en, pc, reg_1, reg_2, imm, aluop, out_ready,
                   input in_ready, out_valid, alu_result, zero);
    modport slave(input in_valid, pc_en, imm_en, pc, reg_1, reg_2, imm, aluop, out_ready,
                  output in_ready, out_valid, alu_result, zero);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; single-cycle ops finish in one step, MUL runs
// a shift-add loop consuming one multiplier bit per cycle.
module alu_mc #(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    localparam logic [3:0] OP_MUL = 4'd10;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [DATA_W-1:0] op_a, op_b, alu, addend, acc;
    logic [3:0]        op_q, op_d;
    logic [SH_W-1:0]   cnt_q, cnt_d, sh;
    logic              zero_q, zero_d;

    always_comb begin
        op_a = bus.pc_en ? bus.pc : bus.reg_1;
        op_b = bus.imm_en ? bus.imm : bus.reg_2;
        sh = op_b[SH_W-1:0];
        alu = '0;
        case (bus.aluop)
            4'd0: alu = op_a | op_b;
            4'd1: alu = op_a & op_b;
            4'd2: alu = op_a ^ op_b;
            4'd3: alu = op_a + op_b;
            4'd4: alu = op_a - op_b;
            4'd5: alu = op_a << sh;
            4'd6: alu = op_a >> sh;
            4'd7: alu = $signed(op_a) >>> sh;
            4'd8: alu = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9: alu = {{(DATA_W-1){1'b0}}, op_a < op_b};
            default: alu = '0;
        endcase
    end

    // a_q walks left and b_q walks right so bit 0 of b_q is always the current multiplier bit
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        op_d = op_q;
        cnt_d = cnt_q;
        res_d = res_q;
        zero_d = zero_q;
        addend = (op_q == OP_MUL && b_q[0]) ? a_q : '0;
        acc = res_q + addend;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d = op_a;
                b_d = op_b;
                op_d = bus.aluop;
                state_d = (bus.aluop == OP_MUL) ? MUL : DONE;
                cnt_d = SH_W'(DATA_W - 1);
                res_d = (bus.aluop == OP_MUL) ? '0 : alu;
                zero_d = (bus.aluop != OP_MUL) && (alu == '0);
            end
            MUL: begin
                res_d = acc;
                a_d = a_q << 1;
                b_d = b_q >> 1;
                cnt_d = cnt_q - SH_W'(1);
                state_d = (cnt_q == '0) ? DONE : MUL;
                zero_d = acc == '0;
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            zero_q <= zero_d;
        end
    end

    assign bus.in_ready = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.alu_result = res_q;
    assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors, corner sequences and random ops checked
// against an arithmetic reference model of the ALU.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_mc_if #(.DATA_W(32)) bus();
    alu_mc #(.DATA_W(32)) dut(.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        pe, ie;
        logic [31:0] pc, r1, r2, imm;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        int          hold;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int unsigned s;
        longint unsigned p;
        s = b % 32;
        p = longint'(a) * longint'(b);
        case (op)
            0: return a | b;
            1: return a & b;
            2: return a ^ b;
            3: return a + b;
            4: return a - b;
            5: return a << s;
            6: return a >> s;
            7: return 32'($signed(a) >>> s);
            8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            10: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic pe, input logic ie, input logic [31:0] p, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] im, input logic [3:0] op);
        bus.pc_en = pe;
        bus.imm_en = ie;
        bus.pc = p;
        bus.reg_1 = r1;
        bus.reg_2 = r2;
        bus.imm = im;
        bus.aluop = op;
    endtask

    // junk requests while busy must be ignored and must not disturb the captured operands
    task automatic run_op(input string name, input logic pe, input logic ie, input logic [31:0] p,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                          input logic [3:0] op, input int hold, output logic [31:0] res, output logic z);
        int lat;
        drive(pe, ie, p, r1, r2, im, op);
        bus.in_valid = 1'b1;
        check({name, "_ready"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        lat = 1;
        drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 9)));
        while (!bus.out_valid && lat < 100) begin
            check({name, "_busy_ready"}, bus.in_ready, 1'b0);
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, (op == 4'd10) ? 33 : 1);
        check({name, "_done_ready"}, bus.in_ready, 1'b0);
        res = bus.alu_result;
        z = bus.zero;
        bus.in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_res"}, bus.alu_result, res);
            check({name, "_hold_valid"}, bus.out_valid, 1'b1);
            check({name, "_hold_ready"}, bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({name, "_idle_ready"}, bus.in_ready, 1'b1);
        check({name, "_idle_valid"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] res, a, b, exp;
        logic z;
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h5, 32'h0, 32'h3, 4'd4, 32'h2, 1'b0, 5});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h0, 32'h4, 32'h0, 4'd7, 32'hF8000000, 1'b0, 0});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h0, 32'h4, 32'h0, 4'd6, 32'h08000000, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd8, 32'h1, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 4'd9, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h00010003, 32'h7, 32'h0, 4'd10, 32'h00070015, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hF0F00000, 32'h00000F0F, 32'h0, 4'd0, 32'hF0F00F0F, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 4'd1, 32'h0F000F00, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hAAAA5555, 32'hAAAA5555, 32'h0, 4'd2, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1, 4'd3, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h12345678, 32'h20, 32'h0, 4'd5, 32'h12345678, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h3, 32'd31, 32'h0, 4'd5, 32'h80000000, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h80000001, 32'h0, 32'h0, 4'd7, 32'h80000001, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h7, 32'hFFFFFFFE, 32'h0, 4'd8, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h7, 32'hFFFFFFFE, 32'h0, 4'd9, 32'h1, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h1234, 32'h5678, 32'h0, 4'd13, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 4'd10, 32'h0, 1'b1, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'd10, 32'h1, 1'b0, 0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'h1, 32'h0, 4'd4, 32'hFFFFFFFF, 1'b0, 0});

        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        drive(1'b0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.alu_result, 32'h0);
        check("rst_zero", bus.zero, 1'b0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("post_rst_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        check("rst_no_accept_valid", bus.out_valid, 1'b0);
        check("rst_no_accept_ready", bus.in_ready, 1'b1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].pe, vecs[i].ie, vecs[i].pc, vecs[i].r1, vecs[i].r2,
                   vecs[i].imm, vecs[i].op, vecs[i].hold, res, z);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_zero", i), z, vecs[i].z);
        end

        drive(1'b0, 1'b0, 32'h0, 32'h00010003, 32'h7, 32'h0, 4'd10);
        bus.in_valid = 1'b1;
        check("abort_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy", bus.in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", bus.out_valid, 1'b0);
        check("abort_result", bus.alu_result, 32'h0);
        check("abort_zero", bus.zero, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            check("abort_no_pulse", bus.out_valid, 1'b0);
        end

        for (int i = 0; i < 150; i++) begin
            logic pe, ie;
            logic [31:0] p, r1, r2, im;
            logic [3:0] op;
            pe = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            p = $urandom;
            r1 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            r2 = ($urandom_range(0, 7) == 0) ? r1 : $urandom;
            im = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            op = 4'($urandom_range(0, 15));
            a = pe ? p : r1;
            b = ie ? im : r2;
            exp = model(a, b, op);
            run_op("rnd", pe, ie, p, r1, r2, im, op, $urandom_range(0, 2), res, z);
            check("rnd_result", res, exp);
            check("rnd_zero", z, exp == 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_W, default 32, sets datapath width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter SH_W, default $clog2(DATA_W), sets the shift-amount width; SHALL NOT be overridden.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 pc_en  input  1  operand A select: 1 = pc, 0 = reg_1.
REQ-009 imm_en  input  1  operand B select: 1 = imm, 0 = reg_2.
REQ-010 pc, reg_1, reg_2, imm  input  DATA_W each  operand sources.
REQ-011 aluop  input  4  operation code, per REQ-016.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 alu_result  output  DATA_W  registered result.
REQ-015 zero  output  1  registered; 1 when alu_result == 0.

Function
REQ-016 Opcodes:
- 0 OR; 1 AND; 2 XOR; 3 ADD; 4 SUB (A-B), all modulo 2^DATA_W
- 5 SLL, 6 SRL, 7 SRA by B[SH_W-1:0]
- 8 SLT signed, 9 SLTU unsigned; result 1 or 0, zero-extended
- 10 MUL: low DATA_W bits of A*B
- 11-15: result 0
REQ-017 States: IDLE, MUL, DONE; in_ready = (state == IDLE), combinational from state only.
REQ-018 Accept = in_valid & in_ready; on accept, A, B and aluop SHALL be captured into registers. Later input changes SHALL NOT affect the result.
REQ-019 Accepted opcodes other than 10 SHALL go IDLE -> DONE with the result registered; out_valid high on the cycle after accept (latency 1).
REQ-020 Opcode 10 SHALL go IDLE -> MUL and run iterative shift-add, one multiplier bit per cycle, counter DATA_W-1 down to 0.
REQ-021 MUL -> DONE when the counter reaches 0; out_valid high exactly DATA_W+1 cycles after accept.
REQ-022 In DONE, out_valid = 1 and alu_result/zero SHALL hold stable until out_ready is sampled high; then DONE -> IDLE.
REQ-023 out_valid SHALL be 0 in IDLE and MUL; at most one operation in flight; in_ready low in MUL and DONE.
REQ-024 Throughput: single-cycle ops at most one per 2 cycles; MUL at most one per DATA_W+2 cycles.
REQ-025 A request presented while in_ready = 0 SHALL be ignored; the source holds it until accepted.
REQ-026 Shift amounts at or above DATA_W cannot occur (only SH_W bits are used); a shift by 0 passes A unchanged.
REQ-027 SRA SHALL replicate A[DATA_W-1]; SLT SHALL compare as two's complement.
REQ-028 MUL with either operand 0 SHALL still take the full DATA_W cycles.

Reset
REQ-029 While rst = 1 at a clk edge: state IDLE; out_valid, alu_result, zero, MUL counter and captured operands all 0.
REQ-030 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-031 Reset in MUL or DONE SHALL abort the operation; no out_valid for it after reset.
REQ-032 in_valid during rst SHALL NOT be accepted.

Verification
REQ-033 DATA_W=32, reg_1=0x0000_0005, imm=0x0000_0003, imm_en=1, aluop=4 -> next cycle out_valid=1, alu_result=0x0000_0002, zero=0.
REQ-034 pc_en=1, pc=0x8000_0000, reg_2=4, aluop=7 -> alu_result=0xF800_0000; with aluop=6 -> 0x0800_0000.
REQ-035 reg_1=0xFFFF_FFFF, reg_2=1, aluop=8 -> 1; aluop=9 -> 0, zero=1.
REQ-036 reg_1=0x0001_0003, reg_2=0x0000_0007, aluop=10 -> in_ready low for 33 cycles, out_valid on cycle 33 after accept, alu_result=0x0007_0015.
REQ-037 Result held with out_ready=0 for 5 cycles -> alu_result stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-038 rst=1 at cycle 10 of a MUL -> next cycle all outputs 0, in_ready=1, no out_valid pulse.
